// File: rtl/comparator_pipelined.sv
// comparator_pipelined
//   Pipelined magnitude comparator. Operands are compared CHUNK bits at a
//   time, most significant slice first, with one slice per stage. Each
//   transaction can be signed or unsigned. Both sides use a valid/ready
//   stream, and the pipeline sustains one compare per cycle.
//
//   Parameters: WIDTH (operand width, multiple of CHUNK), CHUNK (bits per
//   stage, STAGES = WIDTH/CHUNK), TAG_WIDTH (sideband tag width).
//
//   Ports:
//     Clock_In, Reset_In (async, active-high), Enable_In (global clock-enable)
//     Valid_In/Ready_Out, Signed_Mode_In, Data_A_In, Data_B_In, Tag_In : input stream
//     Valid_Out/Ready_In, A_gt_B_Out, A_eq_B_Out, A_lt_B_Out, Tag_Out  : result stream
//     Max_Out, Min_Out : only when COMPARATOR_PIPELINED_MINMAX_EN is defined
//
//   Optional feature macro: COMPARATOR_PIPELINED_MINMAX_EN
module comparator_pipelined #(
  parameter int WIDTH     = 16,
  parameter int CHUNK     = 4,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 Clock_In,
  input  logic                 Reset_In,
  input  logic                 Enable_In,
  input  logic                 Valid_In,
  output logic                 Ready_Out,
  input  logic                 Signed_Mode_In,
  input  logic [WIDTH-1:0]     Data_A_In,
  input  logic [WIDTH-1:0]     Data_B_In,
  input  logic [TAG_WIDTH-1:0] Tag_In,
  output logic                 Valid_Out,
  input  logic                 Ready_In,
  output logic                 A_gt_B_Out,
  output logic                 A_eq_B_Out,
  output logic                 A_lt_B_Out,
  output logic [TAG_WIDTH-1:0] Tag_Out
`ifdef COMPARATOR_PIPELINED_MINMAX_EN
  ,
  output logic [WIDTH-1:0]     Max_Out,
  output logic [WIDTH-1:0]     Min_Out
`endif
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam logic [CHUNK-1:0] SLICE_MSB = CHUNK'(1) << (CHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("comparator_pipelined: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
  end

  // Per-stage state, stage STAGES-1 is the output register.
  logic [STAGES-1:0]    vld_s, gt_s, lt_s, adv;
  logic [TAG_WIDTH-1:0] tag_s [STAGES];
  logic [WIDTH-1:0]     a_s   [STAGES];
  logic [WIDTH-1:0]     b_s   [STAGES];

  // A stage loads when it is empty or its contents move on this cycle,
  // so bubbles collapse instead of travelling down the pipe.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !vld_s[STAGES-1] || Ready_In;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !vld_s[k] || adv[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                 in_vld, in_gt, in_lt;
    logic [TAG_WIDTH-1:0] in_tag;
    logic [CHUNK-1:0]     sl_a, sl_b;
    logic                 gt_d, lt_d;
    logic                 vld_q, gt_q, lt_q;
    logic [TAG_WIDTH-1:0] tag_q;

    if (k == 0) begin : g_head
      assign in_vld = Valid_In;
      assign in_tag = Tag_In;
      assign in_gt  = 1'b0;
      assign in_lt  = 1'b0;
      // Flipping both sign bits turns a two's-complement compare into an
      // unsigned one; the sign bit always falls in slice 0.
      assign sl_a = Data_A_In[WIDTH-1 -: CHUNK] ^ (Signed_Mode_In ? SLICE_MSB : '0);
      assign sl_b = Data_B_In[WIDTH-1 -: CHUNK] ^ (Signed_Mode_In ? SLICE_MSB : '0);
    end else begin : g_body
      assign in_vld = vld_s[k-1];
      assign in_tag = tag_s[k-1];
      assign in_gt  = gt_s[k-1];
      assign in_lt  = lt_s[k-1];
      assign sl_a   = a_s[k-1][WIDTH-1-k*CHUNK -: CHUNK];
      assign sl_b   = b_s[k-1][WIDTH-1-k*CHUNK -: CHUNK];
    end

    // Once a more significant slice has decided, lower slices are ignored.
    assign gt_d = (in_gt | in_lt) ? in_gt : (sl_a > sl_b);
    assign lt_d = (in_gt | in_lt) ? in_lt : (sl_a < sl_b);

    always_ff @(posedge Clock_In or posedge Reset_In) begin
      if (Reset_In) begin
        vld_q <= 1'b0;
        gt_q  <= 1'b0;
        lt_q  <= 1'b0;
        tag_q <= '0;
      end else if (Enable_In && adv[k]) begin
        vld_q <= in_vld;
        gt_q  <= in_vld & gt_d;
        lt_q  <= in_vld & lt_d;
        tag_q <= in_vld ? in_tag : '0;
      end
    end

    assign vld_s[k] = vld_q;
    assign gt_s[k]  = gt_q;
    assign lt_s[k]  = lt_q;
    assign tag_s[k] = tag_q;

    // Operands are only needed by stages that still have slices downstream.
    if (k < STAGES - 1) begin : g_ops
      logic [WIDTH-1:0] a_q, b_q;
      logic [WIDTH-1:0] op_a, op_b;
      if (k == 0) begin : g_src_port
        assign op_a = Data_A_In;
        assign op_b = Data_B_In;
      end else begin : g_src_stage
        assign op_a = a_s[k-1];
        assign op_b = b_s[k-1];
      end
      always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
          a_q <= '0;
          b_q <= '0;
        end else if (Enable_In && adv[k]) begin
          a_q <= op_a;
          b_q <= op_b;
        end
      end
      assign a_s[k] = a_q;
      assign b_s[k] = b_q;
    end

    if (k == STAGES - 1) begin : g_out
      logic eq_q;
      always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
          eq_q <= 1'b0;
        end else if (Enable_In && adv[k]) begin
          eq_q <= in_vld & !(gt_d | lt_d);
        end
      end
      assign A_eq_B_Out = eq_q;

`ifdef COMPARATOR_PIPELINED_MINMAX_EN
      logic [WIDTH-1:0] fin_a, fin_b, max_q, min_q;
      if (k == 0) begin : g_fin_port
        assign fin_a = Data_A_In;
        assign fin_b = Data_B_In;
      end else begin : g_fin_stage
        assign fin_a = a_s[k-1];
        assign fin_b = b_s[k-1];
      end
      always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
          max_q <= '0;
          min_q <= '0;
        end else if (Enable_In && adv[k]) begin
          max_q <= !in_vld ? '0 : (lt_d ? fin_b : fin_a);
          min_q <= !in_vld ? '0 : (lt_d ? fin_a : fin_b);
        end
      end
      assign Max_Out = max_q;
      assign Min_Out = min_q;
`endif
    end
  end

  assign Ready_Out  = Enable_In && !Reset_In && adv[0];
  assign Valid_Out  = vld_s[STAGES-1];
  assign A_gt_B_Out = gt_s[STAGES-1];
  assign A_lt_B_Out = lt_s[STAGES-1];
  assign Tag_Out    = tag_s[STAGES-1];

endmodule

// File: tb/tb_comparator_pipelined.sv
module tb_comparator_pipelined;
  localparam int W  = 16;
  localparam int C  = 4;
  localparam int TW = 4;
  localparam int S  = W / C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, vin, rdy_o, smode, vout, rdy_i, gt, eq, lt;
  logic [W-1:0]  a, b;
  logic [TW-1:0] tag_i, tag_o;
`ifdef COMPARATOR_PIPELINED_MINMAX_EN
  logic [W-1:0]  mx, mn;
`endif

  comparator_pipelined #(.WIDTH(W), .CHUNK(C), .TAG_WIDTH(TW)) dut (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Valid_In(vin), .Ready_Out(rdy_o),
    .Signed_Mode_In(smode), .Data_A_In(a), .Data_B_In(b), .Tag_In(tag_i),
    .Valid_Out(vout), .Ready_In(rdy_i), .A_gt_B_Out(gt), .A_eq_B_Out(eq), .A_lt_B_Out(lt),
    .Tag_Out(tag_o)
`ifdef COMPARATOR_PIPELINED_MINMAX_EN
    , .Max_Out(mx), .Min_Out(mn)
`endif
  );

  // Single-stage variant: WIDTH=8, CHUNK=8, one-cycle latency.
  logic          x_en, x_vin, x_rdy_o, x_s, x_vout, x_rdy_i, x_gt, x_eq, x_lt;
  logic [7:0]    x_a, x_b;
  logic [TW-1:0] x_tag_i, x_tag_o;
`ifdef COMPARATOR_PIPELINED_MINMAX_EN
  logic [7:0]    x_mx, x_mn;
`endif

  comparator_pipelined #(.WIDTH(8), .CHUNK(8), .TAG_WIDTH(TW)) dut_x (
    .Clock_In(clk), .Reset_In(rst), .Enable_In(x_en), .Valid_In(x_vin), .Ready_Out(x_rdy_o),
    .Signed_Mode_In(x_s), .Data_A_In(x_a), .Data_B_In(x_b), .Tag_In(x_tag_i),
    .Valid_Out(x_vout), .Ready_In(x_rdy_i), .A_gt_B_Out(x_gt), .A_eq_B_Out(x_eq), .A_lt_B_Out(x_lt),
    .Tag_Out(x_tag_o)
`ifdef COMPARATOR_PIPELINED_MINMAX_EN
    , .Max_Out(x_mx), .Min_Out(x_mn)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int n_drained = 0;

  typedef struct {
    logic [2:0]    flags;   // {gt, eq, lt}
    logic [TW-1:0] tag;
    logic [W-1:0]  mx, mn;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Whole-word reference compare, {gt, eq, lt}.
  function automatic logic [2:0] ref_cmp(input int wd, input logic [31:0] av, input logic [31:0] bv,
                                         input logic sgn);
    longint ax, bx;
    if (sgn) begin
      ax = longint'($signed(av << (32 - wd))) >>> (32 - wd);
      bx = longint'($signed(bv << (32 - wd))) >>> (32 - wd);
    end else begin
      ax = longint'(av);
      bx = longint'(bv);
    end
    if (ax > bx) return 3'b100;
    if (ax == bx) return 3'b010;
    return 3'b001;
  endfunction

  // Scoreboard: expectations pushed at accept, checked and popped at drain.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (!en) check("rdy_when_disabled", rdy_o, 1'b0);
      if (vout) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", vout, 1'b0);
        end else begin
          check("flags", {gt, eq, lt}, exp_q[0].flags);
          check("tag", tag_o, exp_q[0].tag);
`ifdef COMPARATOR_PIPELINED_MINMAX_EN
          check("max", mx, exp_q[0].mx);
          check("min", mn, exp_q[0].mn);
`endif
        end
      end else begin
        check("idle_flags", {gt, eq, lt}, 3'b000);
      end
      if (vout && rdy_i && en && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        n_drained++;
      end
      if (vin && rdy_o && en) begin
        exp_t e;
        e.flags = ref_cmp(W, 32'(a), 32'(b), smode);
        e.tag   = tag_i;
        e.mx    = (e.flags[2] | e.flags[1]) ? a : b;
        e.mn    = (e.flags[2] | e.flags[1]) ? b : a;
        exp_q.push_back(e);
      end
    end
  end

  task automatic single(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                        input logic [2:0] req, input string name);
    int lat;
    @(posedge clk); #1;
    a = av; b = bv; smode = s; vin = 1'b1; tag_i = tag_i + 1'b1;
    @(negedge clk);
    check({name, "_rdy"}, rdy_o, 1'b1);
    @(posedge clk); #1;
    vin = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (vout) break;
    end
    check({name, "_latency"}, 64'(lat), 64'(S));
    check({name, "_flags"}, {gt, eq, lt}, req);
  endtask

  task automatic wait_empty(input int budget);
    int t;
    t = 0;
    while ((exp_q.size() > 0 || vout) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", 64'(t < budget), 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    int d0, seen;
    logic [63:0] snap;
    logic [2:0]  xe;
    logic [TW-1:0] xt;
`ifdef COMPARATOR_PIPELINED_MINMAX_EN
    logic [7:0]  xmx, xmn;
`endif
    rst = 1'b1; en = 1'b1; vin = 1'b0; rdy_i = 1'b1; smode = 1'b0;
    a = '0; b = '0; tag_i = '0;
    x_en = 1'b1; x_vin = 1'b0; x_rdy_i = 1'b1; x_s = 1'b0; x_a = '0; x_b = '0; x_tag_i = '0;

    repeat (2) @(negedge clk);
    check("reset_ready", rdy_o, 1'b0);
    check("reset_valid", vout, 1'b0);
    check("reset_flags", {gt, eq, lt}, 3'b000);
    check("reset_tag", tag_o, '0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed vectors, expected flags worked out by hand.
    single(16'h8000, 16'h7FFF, 1'b0, 3'b100, "u_8000_7fff");
    single(16'hFFFF, 16'hFFFF, 1'b0, 3'b010, "u_ffff_ffff");
    single(16'h0000, 16'h0001, 1'b0, 3'b001, "u_0000_0001");
    single(16'h8000, 16'h7FFF, 1'b1, 3'b001, "s_8000_7fff");
`ifdef COMPARATOR_PIPELINED_MINMAX_EN
    check("s_8000_7fff_max", mx, 16'h7FFF);
    check("s_8000_7fff_min", mn, 16'h8000);
`endif
    single(16'hFFFF, 16'hFFFE, 1'b1, 3'b100, "s_ffff_fffe");
    single(16'h0001, 16'hFFFF, 1'b1, 3'b100, "s_0001_ffff");
    single(16'h0001, 16'hFFFF, 1'b0, 3'b001, "u_0001_ffff");
    single(16'h1234, 16'h1235, 1'b0, 3'b001, "u_last_slice");
    single(16'h2000, 16'h1FFF, 1'b0, 3'b100, "u_first_slice");
    wait_empty(20);

    // Back-to-back burst with a 5-cycle downstream stall.
    d0 = n_drained;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic acc;
          @(posedge clk); #1;
          vin = 1'b1; a = 16'($urandom); b = 16'($urandom);
          if (i % 5 == 0) b = a;
          smode = 1'($urandom_range(0, 1)); tag_i = 4'(i);
          acc = 1'b0;
          for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = rdy_o;
            if (!acc) @(posedge clk);
          end
          if (!acc) check("burst_accept_timeout", 64'(acc), 1'b1);
        end
        @(posedge clk); #1 vin = 1'b0;
      end
      begin
        repeat (8) @(posedge clk);
        #1 rdy_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("stall_ready_out", rdy_o, 1'b0);
        check("stall_valid_out", vout, 1'b1);
        @(posedge clk); #1 rdy_i = 1'b1;
      end
    join
    wait_empty(100);
    check("burst_count", 64'(n_drained - d0), 64'd20);

    // Freeze with two transactions in flight.
    d0 = n_drained;
    @(posedge clk); #1;
    vin = 1'b1; a = 16'h00F0; b = 16'h00E0; smode = 1'b0; tag_i = 4'hA;
    @(posedge clk); #1;
    a = 16'hF000; b = 16'h0001; smode = 1'b1; tag_i = 4'hB;
    @(posedge clk); #1 vin = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 en = 1'b0;
    @(negedge clk);
    check("en_first_valid", vout, 1'b1);
    check("en_first_flags", {gt, eq, lt}, 3'b100);
    snap = {vout, gt, eq, lt, tag_o};
    repeat (2) begin
      @(negedge clk);
      check("en_hold", {vout, gt, eq, lt, tag_o}, snap);
    end
    @(posedge clk); #1 en = 1'b1;
    wait_empty(20);
    check("en_count", 64'(n_drained - d0), 64'd2);

    // Reset with three in flight.
    @(posedge clk); #1;
    vin = 1'b1; a = 16'h0003; b = 16'h0002; tag_i = 4'h1;
    @(posedge clk); #1 a = 16'h0004; tag_i = 4'h2;
    @(posedge clk); #1 a = 16'h0005; tag_i = 4'h3;
    @(posedge clk); #1 vin = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", vout, 1'b0);
    check("midrst_flags", {gt, eq, lt}, 3'b000);
    check("midrst_ready", rdy_o, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (vout) seen++;
    end
    check("midrst_no_result", 64'(seen), 64'd0);

    // Single-stage instance: 100 random pairs, result one cycle after accept.
    xe = '0; xt = '0;
`ifdef COMPARATOR_PIPELINED_MINMAX_EN
    xmx = '0; xmn = '0;
`endif
    for (int i = 0; i <= 100; i++) begin
      @(posedge clk); #1;
      x_vin = (i < 100);
      x_a = 8'($urandom); x_b = 8'($urandom);
      if (i % 7 == 0) x_b = x_a;
      x_s = 1'($urandom_range(0, 1)); x_tag_i = 4'(i);
      @(negedge clk);
      if (i > 0) begin
        check("x_valid", x_vout, 1'b1);
        check("x_flags", {x_gt, x_eq, x_lt}, xe);
        check("x_tag", x_tag_o, xt);
`ifdef COMPARATOR_PIPELINED_MINMAX_EN
        check("x_max", x_mx, xmx);
        check("x_min", x_mn, xmn);
`endif
      end
      check("x_ready", x_rdy_o, 1'b1);
      xe = ref_cmp(8, 32'(x_a), 32'(x_b), x_s);
      xt = x_tag_i;
`ifdef COMPARATOR_PIPELINED_MINMAX_EN
      xmx = (xe[2] | xe[1]) ? x_a : x_b;
      xmn = (xe[2] | xe[1]) ? x_b : x_a;
`endif
    end
    @(negedge clk);
    check("x_idle_valid", x_vout, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
